// File: rtl/fp_soc_mem_mailbox_master_if.sv
// Bus bundle for the mailbox master: Avalon-MM initiator side plus the fabric command and
// response ports. The master modport is the mailbox master's view; slave is the other side.
interface fp_soc_mem_mailbox_master_if #(
   parameter int unsigned ADDR_W = 2
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect;
   logic              avm_write;
   logic [3:0]        avm_byteenable;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [3:0]        cmd_be;
   logic [31:0]       cmd_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;

   modport master (
      output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
      input  avm_readdata,
      input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
      output avm_readdata,
      output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/fp_soc_mem_mailbox_master.sv
// Avalon-MM initiator for the SoC mailbox RAM. Serves single-word fabric commands and keeps a
// shadow copy of the RAM refreshed by background sweeps that yield to commands between words.
module fp_soc_mem_mailbox_master #(
   parameter int unsigned NUM_WORDS      = 4,
   parameter int unsigned ADDR_W         = 2,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned REFRESH_PERIOD = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   fp_soc_mem_mailbox_master_if.master bus,
   input  logic                      refresh_en,
   output logic [32*NUM_WORDS-1:0]   shadow_data,
   output logic                      shadow_valid
);

   localparam int unsigned TMR_W = $clog2(REFRESH_PERIOD + 1);
   localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(REFRESH_PERIOD);
   localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e                      state_q, state_d;
   logic                        cs_q, cs_d;
   logic                        wr_q, wr_d;
   logic [3:0]                  be_q, be_d;
   logic [ADDR_W-1:0]           addr_q, addr_d;
   logic [31:0]                 wdata_q, wdata_d;
   logic                        sweep_acc_q, sweep_acc_d;   // access in flight is a sweep read
   logic [LAT_W-1:0]            lat_q, lat_d;
   logic [ADDR_W-1:0]           sweep_idx_q, sweep_idx_d;
   logic [TMR_W-1:0]            timer_q, timer_d;
   logic [NUM_WORDS-1:0][31:0]  shadow_q, shadow_d;
   logic                        shadow_valid_q, shadow_valid_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
   logic                        ready_q, ready_d;
   logic                        sweep_pending;

   assign sweep_pending = refresh_en && (timer_q == '0);

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         cs_q           <= 1'b0;
         wr_q           <= 1'b0;
         be_q           <= 4'hF;
         addr_q         <= '0;
         wdata_q        <= '0;
         sweep_acc_q    <= 1'b0;
         lat_q          <= '0;
         sweep_idx_q    <= '0;
         timer_q        <= TMR_LOAD;
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         ready_q        <= 1'b1;
      end else begin
         state_q        <= state_d;
         cs_q           <= cs_d;
         wr_q           <= wr_d;
         be_q           <= be_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         sweep_acc_q    <= sweep_acc_d;
         lat_q          <= lat_d;
         sweep_idx_q    <= sweep_idx_d;
         timer_q        <= timer_d;
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         ready_q        <= ready_d;
      end
   end

   // Next-state logic: command arbitration, sweep sequencing, shadow and response updates
   always_comb begin
      state_d        = state_q;
      cs_d           = 1'b0;
      wr_d           = 1'b0;
      be_d           = 4'hF;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      sweep_acc_d    = sweep_acc_q;
      lat_d          = lat_q;
      sweep_idx_d    = sweep_idx_q;
      timer_d        = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = rsp_rdata_q;
      ready_d        = ready_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               state_d     = StIssue;
               cs_d        = 1'b1;
               wr_d        = bus.cmd_write;
               be_d        = bus.cmd_write ? bus.cmd_be : 4'hF;
               addr_d      = bus.cmd_addr;
               wdata_d     = bus.cmd_wdata;
               sweep_acc_d = 1'b0;
               ready_d     = 1'b0;
            end else if (sweep_pending) begin
               state_d     = StIssue;
               cs_d        = 1'b1;
               addr_d      = sweep_idx_q;
               sweep_acc_d = 1'b1;
               ready_d     = 1'b0;
            end else if (!refresh_en && timer_q == '0 && sweep_idx_q != '0) begin
               // Sweep was interrupted by a command and refresh was disabled meanwhile
               sweep_idx_d = '0;
               timer_d     = TMR_LOAD;
            end
         end
         StIssue: begin
            if (wr_q) begin
               for (int b = 0; b < 4; b++) begin
                  if (be_q[b]) shadow_d[addr_q][8*b +: 8] = wdata_q[8*b +: 8];
               end
               state_d = StIdle;
               ready_d = 1'b1;
            end else begin
               state_d = StWait;
               lat_d   = LAT_LOAD;
            end
         end
         StWait: begin
            if (lat_q != '0) begin
               lat_d = lat_q - LAT_W'(1);
            end else begin
               shadow_d[addr_q] = bus.avm_readdata;
               state_d          = StIdle;
               ready_d          = 1'b1;
               if (!sweep_acc_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = bus.avm_readdata;
               end else if (!refresh_en) begin
                  sweep_idx_d = '0;
                  timer_d     = TMR_LOAD;
               end else if (sweep_idx_q == LAST_IDX) begin
                  sweep_idx_d    = '0;
                  shadow_valid_d = 1'b1;
                  timer_d        = TMR_LOAD;
               end else begin
                  sweep_idx_d = sweep_idx_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.avm_address    = addr_q;
   assign bus.avm_chipselect = cs_q;
   assign bus.avm_write      = wr_q;
   assign bus.avm_byteenable = be_q;
   assign bus.avm_writedata  = wdata_q;
   assign bus.cmd_ready      = ready_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_rdata      = rsp_rdata_q;
   assign shadow_data        = shadow_q;
   assign shadow_valid       = shadow_valid_q;

endmodule

// File: tb/tb_fp_soc_mem_mailbox_master.sv
// Directed bench for the mailbox master with a single-cycle-latency RAM model, an access log
// of chipselect cycles and a read-response scoreboard.
module tb_fp_soc_mem_mailbox_master;

   localparam int unsigned NW  = 4;
   localparam int unsigned AW  = 2;
   localparam int unsigned RL  = 1;
   localparam int unsigned RP  = 8;

   typedef struct packed {
      int          cyc;
      logic [1:0]  addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
   } acc_t;

   typedef struct packed {
      int          cyc;
      logic [31:0] data;
   } rsp_t;

   logic              clk;
   logic              reset_n;
   logic              refresh_en;
   logic [32*NW-1:0]  shadow_data;
   logic              shadow_valid;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   acc_t acc_log[$];
   rsp_t exp_rsp[$];
   rsp_t got;
   acc_t mon_acc;

   logic [31:0] ram [NW];
   logic [31:0] ref_mem [NW];
   logic        bd_we;
   logic [1:0]  bd_addr;
   logic [31:0] bd_data;

   fp_soc_mem_mailbox_master_if #(.ADDR_W(AW)) bus ();

   fp_soc_mem_mailbox_master #(
      .NUM_WORDS(NW),
      .ADDR_W(AW),
      .READ_LATENCY(RL),
      .REFRESH_PERIOD(RP)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .refresh_en(refresh_en),
      .shadow_data(shadow_data),
      .shadow_valid(shadow_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM model: fixed one-cycle read latency, byte-enabled writes, plus a backdoor port
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      if (bus.avm_chipselect) begin
         if (bus.avm_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.avm_byteenable[b]) ram[bus.avm_address][8*b +: 8] <= bus.avm_writedata[8*b +: 8];
         end else begin
            bus.avm_readdata <= ram[bus.avm_address];
         end
      end
   end

   // Monitor: log bus accesses and score read responses
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.avm_chipselect) begin
            mon_acc.cyc  = cyc;
            mon_acc.addr = bus.avm_address;
            mon_acc.wr   = bus.avm_write;
            mon_acc.be   = bus.avm_byteenable;
            mon_acc.data = bus.avm_writedata;
            acc_log.push_back(mon_acc);
         end
         if (bus.rsp_valid) begin
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               got = exp_rsp.pop_front();
               check("rsp_rdata", bus.rsp_rdata, got.data);
               check("rsp_cycle", cyc, got.cyc);
               check("rsp_with_ready", bus.cmd_ready, 1);
            end
         end
      end
   end

   task automatic backdoor(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
      ref_mem[a] = d;
   endtask

   // Presents a command, holds it until accepted; returns #1 after the accept edge
   task automatic send(input logic wr, input logic [1:0] a, input logic [3:0] be,
                       input logic [31:0] d);
      int   waited = 0;
      rsp_t r;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
      bus.cmd_be = be; bus.cmd_wdata = d;
      while (!bus.cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("cmd_accept_timeout", (waited < 50) ? 1 : 0, 1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      if (wr) begin
         for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
         // Accept edge E: address in cycle E+1, capture at E+1+RL, response one cycle later
         r.cyc = cyc + 1 + RL;
         r.data = ref_mem[a];
         exp_rsp.push_back(r);
      end
   endtask

   task automatic drain_rsp();
      int k = 0;
      while (exp_rsp.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rsp_drain", exp_rsp.size(), 0);
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (acc_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_log", (acc_log.size() >= n) ? 1 : 0, 1);
   endtask

   initial begin
      int k;
      reset_n = 1'b0; refresh_en = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_be = '0; bus.cmd_wdata = '0; bus.avm_readdata = '0;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_cs", bus.avm_chipselect, 0);
      check("rst_be", bus.avm_byteenable, 4'hF);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_shadow_valid", shadow_valid, 0);
      check("rst_shadow", shadow_data, 0);
      reset_n = 1'b1;
      for (int i = 0; i < NW; i++) backdoor(2'(i), 32'h0);

      // Write then read back word 2
      send(1'b1, 2'd2, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      check("wr_cs", {bus.avm_chipselect, bus.avm_write}, 2'b11);
      check("wr_addr", bus.avm_address, 2);
      check("wr_be_data", {bus.avm_byteenable, bus.avm_writedata}, {4'hF, 32'hDEADBEEF});
      check("wr_busy", bus.cmd_ready, 0);
      @(negedge clk);
      check("wr_done_ready", bus.cmd_ready, 1);
      check("wr_done_cs", bus.avm_chipselect, 0);
      send(1'b0, 2'd2, 4'h0, 32'h0);
      drain_rsp();
      check("shadow_w2", shadow_data[95:64], 32'hDEADBEEF);

      // Byte-enabled merge on word 1
      send(1'b1, 2'd1, 4'hF, 32'h11223344);
      send(1'b1, 2'd1, 4'b0101, 32'hAABBCCDD);
      repeat (2) @(negedge clk);
      check("merge_ram", ram[1], 32'h11BB33DD);
      check("merge_shadow", shadow_data[63:32], 32'h11BB33DD);
      send(1'b0, 2'd1, 4'h0, 32'h0);
      drain_rsp();

      // Sweep of a preloaded RAM
      for (int i = 0; i < NW; i++) backdoor(2'(i), 32'hA0 + 32'(i));
      acc_log.delete();
      refresh_en = 1'b1;
      k = 0;
      while (!shadow_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("sweep_shadow_valid", shadow_valid, 1);
      check("sweep_shadow", shadow_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      check("sweep_count", acc_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("sweep_addr", {acc_log[i].wr, acc_log[i].addr}, {1'b0, 2'(i)});
         if (i > 0) check("sweep_spacing", acc_log[i].cyc - acc_log[i-1].cyc, 2 + RL);
      end
      // Last word: ISSUE, RL wait cycles, RP timer cycles, then one IDLE decision cycle
      wait_log(5, 40);
      check("sweep2_addr", acc_log[4].addr, 0);
      check("sweep2_gap", acc_log[4].cyc - acc_log[3].cyc, RP + 2 + RL);

      // Command read arriving mid-sweep is served first; sweep resumes at word 2
      wait_log(6, 20);
      send(1'b0, 2'd3, 4'h0, 32'h0);
      wait_log(9, 30);
      check("prio_cmd", acc_log[6].addr, 3);
      check("prio_resume", acc_log[7].addr, 2);
      check("prio_next", acc_log[8].addr, 3);
      drain_rsp();

      // Drop refresh_en after word 1 of the next sweep is issued
      backdoor(2'd1, 32'hB1);
      wait_log(11, 40);
      refresh_en = 1'b0;
      check("drop_w0", acc_log[9].addr, 0);
      check("drop_w1", acc_log[10].addr, 1);
      repeat (4) @(negedge clk);
      check("drop_no_more", acc_log.size(), 11);
      check("drop_shadow_w1", shadow_data[63:32], 32'hB1);
      check("drop_shadow_valid", shadow_valid, 1);
      refresh_en = 1'b1;
      wait_log(12, 40);
      check("restart_addr", acc_log[11].addr, 0);
      check("restart_gap", acc_log[11].cyc - acc_log[10].cyc, RP + 2 + RL);

      // Asynchronous reset in the middle of a command read
      send(1'b0, 2'd0, 4'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      refresh_en = 1'b0;
      exp_rsp.delete();
      #1;
      check("arst_rsp_valid", bus.rsp_valid, 0);
      check("arst_cs", bus.avm_chipselect, 0);
      check("arst_ready", bus.cmd_ready, 1);
      check("arst_shadow_valid", shadow_valid, 0);
      check("arst_shadow", shadow_data, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_ready", bus.cmd_ready, 1);
      check("post_rst_shadow", shadow_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
